lab61_led_pwm: RTL and testbench

- Output stage placed directly downstream of the 8-bit LED output PIO.
- Takes the PIO's `out_port` pattern and applies global PWM brightness, optional blink and optional polarity inversion before driving the board LEDs.
- Configured by the NIOS through its own zero-wait-state Avalon-MM slave, using the same slave signalling as the PIO.

---
 rtl/lab61_led_pkg.sv | 19 +
 rtl/lab61_pwm_timebase.sv | 33 +++
 rtl/lab61_led_pwm.sv | 115 +++++++++++
 tb/tb_lab61_led_pwm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lab61_led_pkg.sv
// Shared constants for the LED PWM output stage: register map, CTRL bit positions
// and the "always on" duty code.
package lab61_led_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DUTY   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_HALF   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_BLINK = 0;
  localparam int unsigned CTRL_INV   = 1;

  localparam logic [LED_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/lab61_pwm_timebase.sv
// PWM timebase: prescaler producing one tick every PRESCALE clocks and an
// 8-bit frame counter advanced on each tick.
module lab61_pwm_timebase #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       tick_c,
  output logic [7:0] pwm_cnt,
  output logic       frame_end_c
);

  localparam int unsigned PRESC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc;

  assign tick_c      = (presc == PRESC_LAST);
  assign frame_end_c = tick_c && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick_c ? '0 : presc + PRESC_W'(1);
      if (tick_c) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lab61_led_pwm.sv
// LED output stage behind the LED PIO: global PWM brightness, optional blink and
// polarity inversion, configured through a zero-wait-state Avalon-MM slave.
module lab61_led_pwm
  import lab61_led_pkg::*;
#(
  parameter int unsigned PRESCALE   = 50,
  parameter int unsigned BLINK_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  input  logic [LED_W-1:0]      led_in,
  output logic [LED_W-1:0]      led_out
);

  logic [LED_W-1:0]      duty;
  logic [BLINK_BITS-1:0] half;
  logic                  blink_en;
  logic                  invert;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  phase;

  logic       tick_c;
  logic       frame_end_c;
  logic [7:0] pwm_cnt;
  logic       we_c;
  logic       blink_restart_c;
  logic       pwm_on_c;
  logic       unused_wdata;

  lab61_pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_c     (tick_c),
    .pwm_cnt    (pwm_cnt),
    .frame_end_c(frame_end_c)
  );

  assign we_c = chipselect && !write_n;
  assign unused_wdata = ^{writedata, tick_c};

  // Reprogramming the blink period or toggling blink_en restarts the blink cycle lit.
  assign blink_restart_c = we_c && ((address == ADDR_HALF) ||
                           ((address == ADDR_CTRL) && (writedata[CTRL_BLINK] != blink_en)));

  always_comb begin
    pwm_on_c = (pwm_cnt < duty);
    if (duty == DUTY_FULL) begin
      pwm_on_c = 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DUTY:   readdata = DATA_W'(duty);
      ADDR_HALF:   readdata = DATA_W'(half);
      ADDR_CTRL:   readdata = DATA_W'({invert, blink_en});
      ADDR_STATUS: readdata = DATA_W'(phase);
      default:     readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty     <= DUTY_FULL;
      half     <= '0;
      blink_en <= 1'b0;
      invert   <= 1'b0;
    end else if (we_c) begin
      case (address)
        ADDR_DUTY: duty <= writedata[LED_W-1:0];
        ADDR_HALF: half <= writedata[BLINK_BITS-1:0];
        ADDR_CTRL: begin
          blink_en <= writedata[CTRL_BLINK];
          invert   <= writedata[CTRL_INV];
        end
        default: ;
      endcase
    end
  end

  // Blink: phase flips after HALF complete PWM frames.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_restart_c || !blink_en || (half == '0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_end_c) begin
      if (blink_cnt == half - BLINK_BITS'(1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= (led_in & {LED_W{pwm_on_c & phase}}) ^ {LED_W{invert}};
    end
  end

endmodule

// File: tb/tb_lab61_led_pwm.sv
// Directed self-checking bench for lab61_led_pwm with PRESCALE=2, BLINK_BITS=4
// (one tick per 2 clocks, one PWM frame per 512 clocks).
module tb_lab61_led_pwm;

  localparam int unsigned PRESCALE   = 2;
  localparam int unsigned BLINK_BITS = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  led_in     = 8'h00;
  logic [7:0]  led_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lab61_led_pwm #(
    .PRESCALE  (PRESCALE),
    .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_in    (led_in),
    .led_out   (led_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  // Length (in clocks) of the led_out run that begins at the current negedge.
  task automatic run_len(input int maxc, output logic [7:0] v, output int n, output logic st);
    v  = led_out;
    n  = 0;
    st = 1'bx;
    do begin
      @(negedge clk);
      n++;
      if (n == 8) st = readdata[0];
    end while (led_out === v && n < maxc);
  endtask

  initial begin
    logic [7:0] v;
    logic       st;
    int         n;
    int         hi;
    int         lo;
    int         other;

    // Reset and release
    led_in = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led_out), 32'h00);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_led", 32'(led_out), 32'hA5);
    check_reg("rst_duty", 2'd0, 32'hFF);
    check_reg("rst_half", 2'd1, 32'h0);
    check_reg("rst_ctrl", 2'd2, 32'h0);
    check_reg("rst_status", 2'd3, 32'h1);

    // DUTY=0x40: 64 of 256 ticks lit per frame
    wr(2'd0, 32'h40);
    led_in = 8'hFF;
    repeat (4) @(negedge clk);
    hi = 0; lo = 0; other = 0;
    repeat (512) begin
      @(negedge clk);
      if (led_out === 8'hFF) hi++;
      else if (led_out === 8'h00) lo++;
      else other++;
    end
    check("pwm40_hi", 32'(hi), 32'd128);
    check("pwm40_lo", 32'(lo), 32'd384);
    check("pwm40_other", 32'(other), 32'd0);
    check_reg("duty_rb", 2'd0, 32'h40);

    // DUTY=0: always dark
    wr(2'd0, 32'h00);
    @(negedge clk);
    hi = 0;
    repeat (600) begin
      @(negedge clk);
      if (led_out !== 8'h00) hi++;
    end
    check("pwm0_lit", 32'(hi), 32'd0);

    // Blink every 3 frames
    led_in = 8'h0F;
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h3);
    wr(2'd2, 32'h1);
    address = 2'd3;
    run_len(4000, v, n, st);
    check("blink_sync_val", 32'(v), 32'h0F);
    check("blink_sync_bound", 32'(n < 4000), 32'd1);
    run_len(4000, v, n, st);
    check("blink_off_val", 32'(v), 32'h00);
    check("blink_off_len", 32'(n), 32'd1536);
    check("blink_off_status", 32'(st), 32'd0);
    run_len(4000, v, n, st);
    check("blink_on_val", 32'(v), 32'h0F);
    check("blink_on_len", 32'(n), 32'd1536);
    check("blink_on_status", 32'(st), 32'd1);

    // Inversion
    wr(2'd2, 32'h2);
    led_in = 8'h81;
    repeat (2) @(negedge clk);
    check("inv_led", 32'(led_out), 32'h7E);
    wr(2'd0, 32'h00);
    repeat (2) @(negedge clk);
    check("inv_duty0", 32'(led_out), 32'hFF);

    // HALF write coinciding with frame_end while phase=0
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h1);
    address = 2'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (readdata[0] !== 1'b0 && n < 3000);
    check("hw_wait_phase0", 32'(n < 3000), 32'd1);
    repeat (511) @(negedge clk);
    address    = 2'd1;
    writedata  = 32'h2;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    #1;
    check("hw_phase_after", 32'(readdata[0]), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (readdata[0] === 1'b1 && n < 3000);
    check("hw_next_toggle", 32'(n), 32'd1024);

    // Reset mid-blink
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h80);
    wr(2'd1, 32'h3);
    repeat (700) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_led", 32'(led_out), 32'h00);
    check_reg("mrst_status", 2'd3, 32'h1);
    check_reg("mrst_duty", 2'd0, 32'hFF);
    check_reg("mrst_half", 2'd1, 32'h0);
    check_reg("mrst_ctrl", 2'd2, 32'h0);
    reset_n = 1'b1;
    led_in  = 8'hA5;
    @(negedge clk);
    check("mrel_led", 32'(led_out), 32'hA5);

    // STATUS is read-only
    wr(2'd3, 32'hFFFF_FFFF);
    check_reg("ro_duty", 2'd0, 32'hFF);
    check_reg("ro_half", 2'd1, 32'h0);
    check_reg("ro_ctrl", 2'd2, 32'h0);
    check_reg("ro_status", 2'd3, 32'h1);
    @(negedge clk);
    check("ro_led", 32'(led_out), 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
